// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] MEM_CTRL_BYTE = 3'b000;
   localparam logic [2:0] MEM_CTRL_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCESS    = 2'd1,
      ACCESS_HI = 2'd2,
      ERR       = 2'd3
   } lsu_state_t;

   function automatic logic funct3_legal(input logic i_we, input logic [2:0] i_f3);
      if (i_we) begin
         return (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W);
      end
      return (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W) ||
             (i_f3 == F3_BU) || (i_f3 == F3_HU);
   endfunction

   // Architectural access size in bytes, from the low funct3 bits.
   function automatic logic [2:0] access_size(input logic [1:0] i_f3_lo);
      case (i_f3_lo)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the loaded byte/half/word from a raw memory word and sign- or zero-extends it.
module load_extend
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_raw,
   output logic [DATA_WIDTH-1:0] o_data
);

   always_comb begin
      o_data = i_raw;
      case (i_funct3)
         F3_B:    o_data = {{(DATA_WIDTH-8){i_raw[7]}}, i_raw[7:0]};
         F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, i_raw[7:0]};
         F3_H:    o_data = {{(DATA_WIDTH-16){i_raw[15]}}, i_raw[15:0]};
         F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, i_raw[15:0]};
         default: o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: holds one byte/word memory access until mem_ready,
// splits SH into two byte writes, and flags illegal ops, range errors and timeouts.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_BYTES  = 131072,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [2:0]            mem_ctrl,
   output logic                  mem_read,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd,
   input  logic                  mem_ready,
   output lsu_state_t            dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]       CNT_MAX   = CW'(TIMEOUT);
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

   lsu_state_t            r_state, w_state_next;
   logic                  r_we;
   logic [2:0]            r_f3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_wdata_hi;
   logic [CW-1:0]         r_cnt, w_cnt_next;

   logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
   logic                  r_mem_we, w_mem_we;
   logic [2:0]            r_mem_ctrl, w_mem_ctrl;
   logic                  r_mem_read, w_mem_read;
   logic [DATA_WIDTH-1:0] r_mem_wd, w_mem_wd;
   logic                  r_resp_valid, w_resp_valid;
   logic                  r_resp_err, w_resp_err;
   logic [DATA_WIDTH-1:0] r_resp_rdata, w_resp_rdata;

   logic [ADDR_WIDTH:0]   w_req_end;
   logic                  w_req_legal;
   logic                  w_req_fire;
   logic                  w_timeout;
   logic                  w_sh_lo;
   logic [DATA_WIDTH-1:0] w_load_data;

   assign w_req_fire  = req_valid && (r_state == IDLE);
   assign w_req_end   = {1'b0, req_addr} +
                        {{(ADDR_WIDTH-2){1'b0}}, access_size(req_funct3[1:0])};
   assign w_req_legal = funct3_legal(req_we, req_funct3) && (w_req_end <= MEM_LIMIT);
   assign w_timeout   = (r_cnt == CNT_MAX);
   assign w_sh_lo     = r_we && (r_f3 == F3_H) && (r_state == ACCESS);

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .i_funct3 (r_f3),
      .i_raw    (mem_rd),
      .o_data   (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) w_state_next = w_req_legal ? ACCESS : ERR;
         end
         ACCESS, ACCESS_HI: begin
            if (w_timeout)      w_state_next = IDLE;
            else if (mem_ready) w_state_next = w_sh_lo ? ACCESS_HI : IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Next values of the registered memory and response outputs.
   always_comb begin
      w_mem_addr   = r_mem_addr;
      w_mem_we     = r_mem_we;
      w_mem_ctrl   = r_mem_ctrl;
      w_mem_read   = r_mem_read;
      w_mem_wd     = r_mem_wd;
      w_cnt_next   = r_cnt;
      w_resp_valid = 1'b0;
      w_resp_err   = 1'b0;
      w_resp_rdata = '0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_cnt_next = '0;
               if (w_req_legal) begin
                  w_mem_addr = req_addr;
                  w_mem_we   = req_we;
                  w_mem_read = !req_we;
                  w_mem_ctrl = (req_we && (req_funct3 != F3_W)) ? MEM_CTRL_BYTE : MEM_CTRL_WORD;
                  if (!req_we)                w_mem_wd = '0;
                  else if (req_funct3 == F3_W) w_mem_wd = req_wdata;
                  else                        w_mem_wd = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
               end
            end
         end
         ACCESS, ACCESS_HI: begin
            if (w_timeout || (mem_ready && !w_sh_lo)) begin
               w_mem_addr   = '0;
               w_mem_we     = 1'b0;
               w_mem_ctrl   = '0;
               w_mem_read   = 1'b0;
               w_mem_wd     = '0;
               w_resp_valid = 1'b1;
               w_resp_err   = w_timeout;
               w_resp_rdata = (w_timeout || r_we) ? '0 : w_load_data;
            end else if (mem_ready) begin
               w_mem_addr = r_addr + ADDR_WIDTH'(1);
               w_mem_wd   = {{(DATA_WIDTH-8){1'b0}}, r_wdata_hi};
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: begin
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_f3         <= '0;
         r_addr       <= '0;
         r_wdata_hi   <= '0;
         r_cnt        <= '0;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_ctrl   <= '0;
         r_mem_read   <= 1'b0;
         r_mem_wd     <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         if (w_req_fire) begin
            r_we       <= req_we;
            r_f3       <= req_funct3;
            r_addr     <= req_addr;
            r_wdata_hi <= req_wdata[15:8];
         end
         r_cnt        <= w_cnt_next;
         r_mem_addr   <= w_mem_addr;
         r_mem_we     <= w_mem_we;
         r_mem_ctrl   <= w_mem_ctrl;
         r_mem_read   <= w_mem_read;
         r_mem_wd     <= w_mem_wd;
         r_resp_valid <= w_resp_valid;
         r_resp_err   <= w_resp_err;
         r_resp_rdata <= w_resp_rdata;
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_ctrl   = r_mem_ctrl;
   assign mem_read   = r_mem_read;
   assign mem_wd     = r_mem_wd;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a latency-programmable memory responder
// plus response and memory-write scoreboards.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_we, mem_read, mem_ready;
   logic [2:0]  mem_ctrl;
   lsu_state_t  dbg_state;

   int          n_checks = 0;
   int          n_fail = 0;
   int          lat = 0;
   logic        hang = 1'b0;
   logic [31:0] mem_word = '0;
   int          age = 0;
   int          strobe_cycles = 0;
   int          writes_seen = 0;
   int          writes_exp = 0;
   logic [32:0] exp_q[$];
   logic [66:0] wr_q[$];

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_read(mem_read),
      .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready), .dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory responder: mem_ready rises 'lat' cycles after an access begins; logs writes.
   initial begin
      logic [66:0] e;
      mem_ready = 1'b0;
      mem_rd    = '0;
      forever begin
         @(negedge clk);
         if (mem_read || mem_we) begin
            if (mem_ready) age = 0;
            age++;
            mem_ready = !hang && (age > lat);
            strobe_cycles++;
         end else begin
            age       = 0;
            mem_ready = 1'b0;
         end
         mem_rd = mem_word;
         if (mem_we && mem_ready) begin
            writes_seen++;
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               chk("wr_addr", mem_addr, e[66:35]);
               chk("wr_wd", mem_wd, e[34:3]);
               chk("wr_ctrl", 32'(mem_ctrl), 32'(e[2:0]));
            end
         end
      end
   end

   task automatic exp_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] ctrl);
      wr_q.push_back({addr, wd, ctrl});
      writes_exp++;
   endtask

   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] word, input int l,
                      input logic h, input logic e_err, input logic [31:0] e_rdata,
                      input int e_k);
      int          k;
      logic [32:0] e;
      lat      = l;
      hang     = h;
      mem_word = word;
      exp_q.push_back({e_err, e_rdata});
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      k = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            k = i;
            break;
         end
      end
      e = exp_q.pop_front();
      if (k == 0) begin
         chk("resp_arrived", 32'(resp_valid), 32'd1);
      end else begin
         chk("resp_rdata", resp_rdata, e[31:0]);
         chk("resp_err", 32'(resp_err), 32'(e[32]));
         chk("resp_latency", 32'(k), 32'(e_k));
         chk("req_ready_at_resp", 32'(req_ready), 32'd1);
         chk("strobes_off_at_resp", {30'h0, mem_we, mem_read}, 32'd0);
         @(negedge clk);
         chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      end
   endtask

   initial begin
      int          snap;
      logic [2:0]  f3s[5];
      logic [2:0]  f3;
      logic [31:0] w;
      int          l;
      f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_strobes", {30'h0, mem_we, mem_read}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b0;

      run(1'b0, F3_W, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 4);
      run(1'b0, F3_B,  32'h20, 32'h0, 32'h0000_80F0, 0, 1'b0, 1'b0, 32'hFFFF_FFF0, 2);
      run(1'b0, F3_BU, 32'h20, 32'h0, 32'h0000_80F0, 1, 1'b0, 1'b0, 32'h0000_00F0, 3);
      run(1'b0, F3_H,  32'h20, 32'h0, 32'h0000_80F0, 3, 1'b0, 1'b0, 32'hFFFF_80F0, 5);
      run(1'b0, F3_HU, 32'h20, 32'h0, 32'h0000_80F0, 0, 1'b0, 1'b0, 32'h0000_80F0, 2);

      exp_wr(32'h100, 32'h0000_00CD, MEM_CTRL_BYTE);
      exp_wr(32'h101, 32'h0000_00AB, MEM_CTRL_BYTE);
      run(1'b1, F3_H, 32'h100, 32'h1234_ABCD, 32'h0, 1, 1'b0, 1'b0, 32'h0, 5);
      exp_wr(32'h100, 32'h1234_ABCD, MEM_CTRL_WORD);
      run(1'b1, F3_W, 32'h100, 32'h1234_ABCD, 32'h0, 2, 1'b0, 1'b0, 32'h0, 4);
      exp_wr(32'h104, 32'h0000_0077, MEM_CTRL_BYTE);
      run(1'b1, F3_B, 32'h104, 32'hCAFE_0077, 32'h0, 0, 1'b0, 1'b0, 32'h0, 2);
      exp_wr(32'h200, 32'h0000_0022, MEM_CTRL_BYTE);
      exp_wr(32'h201, 32'h0000_0011, MEM_CTRL_BYTE);
      run(1'b1, F3_H, 32'h200, 32'h9988_1122, 32'h0, 0, 1'b0, 1'b0, 32'h0, 3);

      // Timeouts: response 17 cycles after the strobe rises, then normal service resumes.
      run(1'b0, F3_W, 32'h40, 32'h0, 32'h5555_AAAA, 0, 1'b1, 1'b1, 32'h0, 18);
      run(1'b0, F3_W, 32'h44, 32'h0, 32'h1357_9BDF, 1, 1'b0, 1'b0, 32'h1357_9BDF, 3);
      run(1'b1, F3_H, 32'h300, 32'hFFFF_BEEF, 32'h0, 0, 1'b1, 1'b1, 32'h0, 18);

      snap = strobe_cycles;
      run(1'b0, 3'b011, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0, 2);
      run(1'b0, 3'b110, 32'h8, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0, 2);
      run(1'b1, 3'b011, 32'h8, 32'h1, 32'h0, 0, 1'b0, 1'b1, 32'h0, 2);
      run(1'b0, F3_W, 32'h0001_FFFE, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0, 2);
      run(1'b1, F3_H, 32'h0001_FFFF, 32'h1234, 32'h0, 0, 1'b0, 1'b1, 32'h0, 2);
      chk("illegal_no_strobe", 32'(strobe_cycles - snap), 32'd0);

      run(1'b0, F3_W, 32'h0001_FFFC, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 3);
      run(1'b0, F3_B, 32'h0001_FFFF, 32'h0, 32'h0000_0085, 0, 1'b0, 1'b0, 32'hFFFF_FF85, 2);

      for (int i = 0; i < 20; i++) begin
         f3 = f3s[$urandom_range(0, 4)];
         w  = $urandom;
         l  = $urandom_range(0, 3);
         run(1'b0, f3, 32'($urandom_range(0, 32'h7FFF)) << 2, 32'h0, w, l, 1'b0, 1'b0,
             ref_ext(f3, w), l + 2);
      end

      // Reset lands on the cycle the SH low byte completes: the high byte must never be written.
      lat = 2; hang = 1'b0;
      exp_wr(32'h100, 32'h0000_003C, MEM_CTRL_BYTE);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H;
      req_addr = 32'h100; req_wdata = 32'h0000_5A3C;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_mem_we", 32'(mem_we), 32'd0);
      chk("rstmid_mem_read", 32'(mem_read), 32'd0);
      chk("rstmid_req_ready", 32'(req_ready), 32'd1);
      chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
      end
      chk("rstmid_writes", 32'(writes_seen), 32'(writes_exp));

      run(1'b0, F3_W, 32'h80, 32'h0, 32'hA5A5_0F0F, 1, 1'b0, 1'b0, 32'hA5A5_0F0F, 3);

      chk("total_writes", 32'(writes_seen), 32'(writes_exp));
      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
